// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads a word over the Avalon-style bus and latches it into the instruction register.
// Latency: capture one edge after fetch_start plus one per waitrequest cycle; read is held for as long as waitrequest is high.
module instr_fetch_unit #(
   parameter int                 ADDR_W       = 32,
   parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'hBFC00000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_start,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_value,
   input  logic              waitrequest,
   input  logic [31:0]       readdata,
   output logic              read,
   output logic [ADDR_W-1:0] address,
   output logic [31:0]       instr,
   output logic [5:0]        opcode,
   output logic              instr_valid,
   output logic              busy,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_error
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_READ = 1'b1;

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_address;
   logic [31:0]       r_instr;
   logic              r_instr_valid;
   logic              r_fetch_error;
   logic              r_pend_vld;
   logic [ADDR_W-1:0] r_pend_pc;

   logic [ADDR_W-1:0] w_load_aligned;
   logic              w_misaligned;

   assign w_load_aligned = {pc_load_value[ADDR_W-1:2], 2'b00};
   assign w_misaligned   = pc_load && (pc_load_value[1:0] != 2'b00);

   // read is decoded from state so the async reset drops it without a clock edge
   assign read        = (r_state == S_READ);
   assign busy        = (r_state == S_READ);
   assign address     = r_address;
   assign instr       = r_instr;
   assign opcode      = r_instr[31:26];
   assign instr_valid = r_instr_valid;
   assign pc          = r_pc;
   assign fetch_error = r_fetch_error;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_VECTOR;
         r_address     <= RESET_VECTOR;
         r_instr       <= 32'h0;
         r_instr_valid <= 1'b0;
         r_fetch_error <= 1'b0;
         r_pend_vld    <= 1'b0;
         r_pend_pc     <= '0;
      end else begin
         r_instr_valid <= 1'b0;
         if (w_misaligned)
            r_fetch_error <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (fetch_start) begin
                  r_state   <= S_READ;
                  r_address <= r_pc;
                  // jump issued with the fetch waits until the fetch completes (delay slot)
                  if (pc_load) begin
                     r_pend_vld <= 1'b1;
                     r_pend_pc  <= w_load_aligned;
                  end
               end else if (pc_load) begin
                  r_pc <= w_load_aligned;
               end
            end
            S_READ: begin
               if (!waitrequest) begin
                  r_state       <= S_IDLE;
                  r_instr       <= readdata;
                  r_instr_valid <= 1'b1;
                  r_pend_vld    <= 1'b0;
                  if (pc_load)
                     r_pc <= w_load_aligned;
                  else if (r_pend_vld)
                     r_pc <= r_pend_pc;
                  else
                     r_pc <= r_pc + ADDR_W'(4);
               end else if (pc_load) begin
                  r_pend_vld <= 1'b1;
                  r_pend_pc  <= w_load_aligned;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
